demux1_4_stream: RTL and testbench

- Clocked, flow-controlled 1:4 demultiplexer for a data stream.
- Accepts one DW-bit beat per cycle on a valid/ready input.
- Routes each beat to one of four output channels, each buffered by a small FIFO.
- Channel choice comes from a 2-bit select (addressed mode) or an internal round-robin pointer; this is the registered, back-pressured counterpart to the combinational 1:4 demux.

---
 rtl/demux1_4_stream_pkg.sv | 14 +
 rtl/demux_chan_fifo.sv | 53 +++++
 rtl/demux1_4_stream.sv | 75 +++++++
 tb/tb_demux1_4_stream.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/demux1_4_stream_pkg.sv
// Shared constants and types for the 1:4 stream demultiplexer.
package demux1_4_stream_pkg;

  localparam int unsigned NCH           = 4;
  localparam int unsigned DEFAULT_DW    = 8;
  localparam int unsigned DEFAULT_DEPTH = 2;
  localparam int unsigned BEAT_CNT_W    = 16;

  typedef enum logic {
    MODE_ADDR = 1'b0,
    MODE_RR   = 1'b1
  } mode_e;

endpackage

// File: rtl/demux_chan_fifo.sv
// Per-channel first-word-fall-through FIFO; head entry is driven straight from the register array.
module demux_chan_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DW-1:0]              data_in,
  output logic                       full,
  input  logic                       pop,
  output logic [DW-1:0]              data_out,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign data_out = mem[rd_ptr];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Storage is deliberately left out of reset; only pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux1_4_stream.sv
// Flow-controlled 1:4 stream demux: addressed or round-robin routing into four channel FIFOs.
module demux1_4_stream
  import demux1_4_stream_pkg::*;
#(
  parameter int unsigned DW    = DEFAULT_DW,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [DW-1:0]         i_data,
  input  logic [1:0]            s,
  input  logic                  mode,
  output logic                  i_ready,
  output logic [NCH-1:0]        y_valid,
  output logic [NCH*DW-1:0]     y_data,
  input  logic [NCH-1:0]        y_ready,
  output logic [1:0]            rr_ptr,
  output logic [BEAT_CNT_W-1:0] beat_cnt
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [1:0]    sel;
  logic          accept;
  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;
  logic [NCH-1:0] full;
  logic [NCH-1:0] empty;
  logic [CW-1:0]  count [NCH];

  assign sel     = (mode_e'(mode) == MODE_RR) ? rr_ptr : s;
  // Readiness sees only registered fullness, so y_ready never reaches i_ready combinationally.
  assign i_ready = !full[sel];
  assign accept  = i_valid && i_ready;
  assign y_valid = ~empty;
  assign pop     = y_ready & y_valid;

  always_comb begin
    push = '0;
    push[sel] = accept;
  end

  for (genvar n = 0; n < NCH; n++) begin : g_chan
    demux_chan_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push[n]),
      .data_in  (i_data),
      .full     (full[n]),
      .pop      (pop[n]),
      .data_out (y_data[n*DW +: DW]),
      .empty    (empty[n]),
      .count    (count[n])
    );

    always_comb begin
      if (rst_n) assert (full[n] == (count[n] == CW'(DEPTH)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
      if (mode_e'(mode) == MODE_RR) rr_ptr <= rr_ptr + 2'd1;
    end
  end

endmodule

// File: tb/tb_demux1_4_stream.sv
// Directed plus randomized bench for demux1_4_stream, checked against a queue-based reference model.
module tb_demux1_4_stream;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic [1:0]    s;
  logic          mode;
  logic          i_ready;
  logic [3:0]    y_valid;
  logic [4*DW-1:0] y_data;
  logic [3:0]    y_ready;
  logic [1:0]    rr_ptr;
  logic [15:0]   beat_cnt;

  int unsigned total  = 0;
  int unsigned passed = 0;

  logic [DW-1:0] q [4][$];
  int unsigned   rr = 0;
  int unsigned   bc = 0;

  always #5 clk = ~clk;

  demux1_4_stream #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .s        (s),
    .mode     (mode),
    .i_ready  (i_ready),
    .y_valid  (y_valid),
    .y_data   (y_data),
    .y_ready  (y_ready),
    .rr_ptr   (rr_ptr),
    .beat_cnt (beat_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_model();
    for (int n = 0; n < 4; n++) q[n].delete();
    rr = 0;
    bc = 0;
  endtask

  // One clock: check outputs at the falling edge, then apply the model's transfer at the rising edge.
  task automatic step();
    int unsigned sel;
    bit          acc;
    bit [3:0]    pops;
    @(negedge clk);
    sel = mode ? rr : int'(s);
    chk("i_ready", 32'(i_ready), 32'(q[sel].size() < DEPTH));
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("y_valid[%0d]", n), 32'(y_valid[n]), 32'(q[n].size() > 0));
      if (q[n].size() > 0)
        chk($sformatf("y_data[%0d]", n), 32'(y_data[n*DW +: DW]), 32'(q[n][0]));
    end
    chk("rr_ptr", 32'(rr_ptr), rr);
    chk("beat_cnt", 32'(beat_cnt), bc);
    acc = i_valid && (q[sel].size() < DEPTH);
    for (int n = 0; n < 4; n++) pops[n] = y_ready[n] && (q[n].size() > 0);
    @(posedge clk);
    for (int n = 0; n < 4; n++) if (pops[n]) void'(q[n].pop_front());
    if (acc) begin
      q[sel].push_back(i_data);
      bc = (bc + 1) % 65536;
      if (mode) rr = (rr + 1) % 4;
    end
    #1;
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input logic [1:0] ss,
                       input bit m, input logic [3:0] yr);
    i_valid = v;
    i_data  = d;
    s       = ss;
    mode    = m;
    y_ready = yr;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    i_valid = 1'b0; i_data = '0; s = '0; mode = 1'b0; y_ready = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset / idle
    drive(0, 8'h00, 2'd0, 0, 4'b0000);
    drive(0, 8'h00, 2'd0, 0, 4'b0000);

    // Addressed routing
    for (int i = 0; i < 4; i++) drive(1, 8'(8'hA0 + i), 2'(i), 0, 4'b1111);
    drive(0, 8'h00, 2'd0, 0, 4'b1111);
    chk("beat_cnt_after_addr", 32'(beat_cnt), 32'd4);

    // Round-robin
    for (int i = 0; i < 6; i++) drive(1, 8'(8'h10 + i), 2'd3, 1, 4'b1111);
    drive(0, 8'h00, 2'd0, 1, 4'b1111);
    chk("rr_ptr_after_rr", 32'(rr_ptr), 32'd2);

    // Back-pressure on channel 2, channel 1 still flows
    for (int i = 0; i < 3; i++) drive(1, 8'(8'h20 + i), 2'd2, 0, 4'b1011);
    drive(1, 8'h30, 2'd1, 0, 4'b1011);
    drive(1, 8'h22, 2'd2, 0, 4'b1011);
    drive(1, 8'h22, 2'd2, 0, 4'b1111);
    drive(1, 8'h22, 2'd2, 0, 4'b1111);
    drive(0, 8'h00, 2'd0, 0, 4'b1111);
    drive(0, 8'h00, 2'd0, 0, 4'b1111);

    // RR stall on channel 1: walk rr to 1 and fill ch1 while it is blocked
    drive(1, 8'h40, 2'd0, 1, 4'b1101);
    drive(1, 8'h41, 2'd0, 1, 4'b1101);
    drive(0, 8'h00, 2'd1, 0, 4'b1101);
    for (int i = 0; i < 3; i++) drive(1, 8'(8'h50 + i), 2'd1, 0, 4'b1101);
    for (int i = 0; i < 3; i++) drive(1, 8'h60, 2'd0, 1, 4'b1101);
    chk("rr_ptr_stalled", 32'(rr_ptr), 32'd1);
    for (int i = 0; i < 4; i++) drive(1, 8'(8'h60 + i), 2'd0, 1, 4'b1111);
    for (int i = 0; i < 3; i++) drive(0, 8'h00, 2'd0, 0, 4'b1111);

    // Fill channels 0 and 3, then asynchronous reset between edges
    drive(1, 8'h70, 2'd0, 0, 4'b0000);
    drive(1, 8'h71, 2'd0, 0, 4'b0000);
    drive(1, 8'h72, 2'd3, 0, 4'b0000);
    drive(1, 8'h73, 2'd3, 0, 4'b0000);
    drive(0, 8'h00, 2'd0, 0, 4'b0000);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_y_valid", 32'(y_valid), 32'h0);
    chk("async_rst_beat_cnt", 32'(beat_cnt), 32'h0);
    chk("async_rst_rr_ptr", 32'(rr_ptr), 32'h0);
    clear_model();
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1, 8'h99, 2'd3, 0, 4'b0000);
    drive(0, 8'h00, 2'd0, 0, 4'b0000);
    drive(0, 8'h00, 2'd0, 0, 4'b1111);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom), 1'($urandom_range(0, 2) == 0),
            4'($urandom | $urandom));
    end
    for (int i = 0; i < 4; i++) drive(0, 8'h00, 2'd0, 0, 4'b1111);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
